dmem_port_arbiter: RTL and testbench
====================================

// Module: dmem_port_arbiter
// PURPOSE
//  Shares the single data-memory port between two masters: the core load/store path (port 0)
//  and the debug/program-loader master (port 1).
//  Round-robin arbitration; registered command toward memory; valid/ready memory handshake.
//  Per-transaction timeout with error response. Sits between core/loader and data_mem.
// PARAMETERS
//  AW       32   address width
//  DW       32   data width
//  TIMEOUT  255  max cycles waiting for mem_ready before abort; 0 disables timeout
// PORTS
//  clk          in   1   clock, rising edge
//  reset_n      in   1   asynchronous, active-low reset
//  req0/req1    in   1   request from port 0 (core) / port 1 (loader); held until ackN
//  we0/we1      in   1   1=write, 0=read; stable while reqN high
//  addr0/addr1  in   AW  byte address; stable while reqN high
//  wdata0/1     in   DW  write data; stable while reqN high
//  ack0/ack1    out  1   one-cycle completion pulse to the owning port
//  err0/err1    out  1   qualifies ackN: transaction timed out
//  rdata        out  DW  read data, valid in the ackN cycle
//  mem_valid    out  1   command valid to memory
//  mem_we       out  1   write enable to memory
//  mem_addr     out  AW  registered address
//  mem_wdata    out  DW  registered write data
//  mem_ready    in   1   memory accepted/completed; mem_rdata valid in this cycle
//  mem_rdata    in   DW  memory read data
// BEHAVIOUR
//  Reset (async, reset_n=0): state=IDLE; all outputs 0; rr_ptr=0 (port 0 favoured).
//  FSM: IDLE -> BUSY -> RESP -> IDLE.
//  IDLE:
//   - Neither req: stay.
//   - One req: grant it.
//   - Both: grant rr_ptr's port.
//   - On grant, register we/addr/wdata into mem_*, set mem_valid=1, owner=N, clear wait_cnt.
//   - Go to BUSY.
//  BUSY:
//   - mem_valid=1; mem_* held constant.
//   - mem_ready=1: capture mem_rdata into rdata (reads only; writes leave rdata unchanged),
//     drop mem_valid, go to RESP.
//   - Else wait_cnt++. With TIMEOUT!=0 and wait_cnt==TIMEOUT-1 while mem_ready=0:
//     drop mem_valid, set error flag, go to RESP.
//   - mem_ready and timeout in the same cycle: mem_ready wins, no error.
//  RESP:
//   - ack<owner>=1 for exactly one cycle; err<owner>=error flag.
//   - rr_ptr = ~owner; go to IDLE.
//  Latency: req seen in cycle N -> mem_valid from N+1. mem_ready in cycle M -> ack in M+1.
//   Minimum 3 cycles per transaction; back-to-back from one port every 3 cycles.
//  Requesters may keep reqN high after ackN to issue a new command (sampled in following IDLE).
//  reqN dropped while owned: ignored; transaction completes and acks anyway.
//  ackN/errN never asserted for the non-owner; ack0 and ack1 never high together.
//  wait_cnt width = clog2(TIMEOUT+1); saturates, never wraps.
//  reset_n asserted mid-transaction: immediate return to IDLE, mem_valid=0, no ack issued;
//   memory side must tolerate abandoned command.
// CONFIGURATION
//  DMEM_ARB_PERF_EN defined:
//   - Adds output conflict_cnt[15:0]: +1 in each IDLE cycle where req0 and req1 are both high.
//   - Saturates at 16'hFFFF; reset to 0.
//   - Adds output timeout_cnt[7:0]: +1 per timed-out transaction; saturates; reset to 0.
//  Undefined: ports and counters absent; arbitration behaviour identical.
// TESTING
//  1 Reset: reset_n=0 mid-BUSY -> mem_valid=0, ack0=ack1=0 same cycle; rr_ptr=0 after release.
//  2 Single read: req0, addr0=0x10, mem_ready 2 cycles after mem_valid, mem_rdata=0xDEADBEEF
//    -> mem_addr=0x10, ack0 pulse, rdata=0xDEADBEEF, err0=0.
//  3 Contention: req0 and req1 high together from reset
//    -> grants alternate port0, port1, port0, port1; conflict_cnt=4 after 4 grants
//    (PERF_EN build).
//  4 Write: req1, we1=1, addr1=0x40, wdata1=0x12345678
//    -> mem_we=1, mem_wdata=0x12345678 held until mem_ready; ack1 only; rdata unchanged.
//  5 Timeout: TIMEOUT=4, mem_ready stuck 0 -> mem_valid drops after 4 cycles;
//    ack0=err0=1; timeout_cnt=1.
//  6 Race: mem_ready in exact timeout cycle -> ack with err=0, rdata captured.

Source files
------------

// File: rtl/dmem_port_arbiter_if.sv
// dmem_port_arbiter_if: requester and memory-side bundle for the
// data-memory port arbiter (master = arbiter, slave = environment).
interface dmem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          req0;
  logic          req1;
  logic          we0;
  logic          we1;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata0;
  logic [DW-1:0] wdata1;
  logic          ack0;
  logic          ack1;
  logic          err0;
  logic          err1;
  logic [DW-1:0] rdata;
  logic          mem_valid;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ready;
  logic [DW-1:0] mem_rdata;

  modport master (
    input  req0, req1, we0, we1,
    input  addr0, addr1, wdata0, wdata1,
    output ack0, ack1, err0, err1, rdata,
    output mem_valid, mem_we,
    output mem_addr, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    output req0, req1, we0, we1,
    output addr0, addr1, wdata0, wdata1,
    input  ack0, ack1, err0, err1, rdata,
    input  mem_valid, mem_we,
    input  mem_addr, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: round-robin share of one data-memory port
// between core (0) and loader (1). DMEM_ARB_PERF_EN adds counters.
module dmem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset_n,
  dmem_port_arbiter_if.master bus
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [15:0] conflict_cnt,
  output logic [7:0]  timeout_cnt
`endif
);

  localparam int CW =
    (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int TL =
    (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CW-1:0] TMO_LAST = TL[CW-1:0];
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next;

  logic          r_owner;
  logic          r_rr;
  logic          r_err;
  logic [CW-1:0] r_wait;
  logic          r_mem_we;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;
  logic [DW-1:0] r_rdata;

  logic          w_any;
  logic          w_both;
  logic          w_sel;
  logic          w_tmo;
  logic          w_done;

  logic          w_mem_valid;
  logic          w_ack0;
  logic          w_ack1;
  logic          w_err0;
  logic          w_err1;

  // A tie goes to the round-robin pointer, a lone request wins outright
  assign w_any  = bus.req0 | bus.req1;
  assign w_both = bus.req0 & bus.req1;
  assign w_sel  = w_both ? r_rr : bus.req1;

  // Last permitted wait cycle with memory still silent; ready wins a tie
  assign w_tmo  = (TIMEOUT != 0)
               && (r_state == S_BUSY)
               && !bus.mem_ready
               && (r_wait == TMO_LAST);

  assign w_done = (r_state == S_BUSY)
               && (bus.mem_ready || w_tmo);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_any)  w_next = S_BUSY;
      S_BUSY: if (w_done) w_next = S_RESP;
      S_RESP: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from the current state
  always_comb begin
    w_mem_valid = 1'b0;
    w_ack0      = 1'b0;
    w_ack1      = 1'b0;
    w_err0      = 1'b0;
    w_err1      = 1'b0;
    unique case (1'b1)
      (r_state == S_BUSY): begin
        w_mem_valid = 1'b1;
      end
      (r_state == S_RESP): begin
        w_ack0 = !r_owner;
        w_ack1 = r_owner;
        w_err0 = !r_owner & r_err;
        w_err1 = r_owner & r_err;
      end
      default: begin
        w_mem_valid = 1'b0;
      end
    endcase
  end

  // Command capture, wait counting, read-data capture, pointer update
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_owner     <= 1'b0;
      r_rr        <= 1'b0;
      r_err       <= 1'b0;
      r_wait      <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rdata     <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_owner     <= w_sel;
            r_err       <= 1'b0;
            r_wait      <= '0;
            r_mem_we    <= w_sel ? bus.we1 : bus.we0;
            r_mem_addr  <= w_sel ? bus.addr1 : bus.addr0;
            r_mem_wdata <= w_sel ? bus.wdata1 : bus.wdata0;
          end
        end
        S_BUSY: begin
          if (bus.mem_ready) begin
            if (!r_mem_we) r_rdata <= bus.mem_rdata;
          end else begin
            if (r_wait != CNT_MAX) r_wait <= r_wait + CW'(1);
            if (w_tmo) r_err <= 1'b1;
          end
        end
        S_RESP: begin
          r_rr <= ~r_owner;
        end
        default: begin
          r_err <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_valid = w_mem_valid;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.ack0      = w_ack0;
  assign bus.ack1      = w_ack1;
  assign bus.err0      = w_err0;
  assign bus.err1      = w_err1;
  assign bus.rdata     = r_rdata;

`ifdef DMEM_ARB_PERF_EN
  logic [15:0] r_conflict;
  logic [7:0]  r_tmo_cnt;

  // Saturating counts of contended idle cycles and timed-out commands
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_conflict <= '0;
      r_tmo_cnt  <= '0;
    end else begin
      if ((r_state == S_IDLE) && w_both
          && (r_conflict != 16'hFFFF))
        r_conflict <= r_conflict + 16'd1;
      if (w_tmo && (r_tmo_cnt != 8'hFF))
        r_tmo_cnt <= r_tmo_cnt + 8'd1;
    end
  end

  assign conflict_cnt = r_conflict;
  assign timeout_cnt  = r_tmo_cnt;
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: directed vectors for dmem_port_arbiter
// (TIMEOUT=4); drives at negedge, samples at negedge.
module tb_dmem_port_arbiter;

  logic clk;
  logic reset_n;
  int   n_cmp;
  int   n_bad;

  dmem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

`ifdef DMEM_ARB_PERF_EN
  logic [15:0] conflict_cnt;
  logic [7:0]  timeout_cnt;
`endif

  dmem_port_arbiter #(
    .AW(32), .DW(32), .TIMEOUT(4)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
`ifdef DMEM_ARB_PERF_EN
    ,
    .conflict_cnt (conflict_cnt),
    .timeout_cnt  (timeout_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_in();
    bus.req0      = 1'b0;
    bus.req1      = 1'b0;
    bus.we0       = 1'b0;
    bus.we1       = 1'b0;
    bus.addr0     = '0;
    bus.addr1     = '0;
    bus.wdata0    = '0;
    bus.wdata1    = '0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  logic [31:0] exp_addr;
  logic        exp_port;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    idle_in();
    reset_n = 1'b0;
    tick();
    tick();
    check("rst_valid", {31'b0, bus.mem_valid}, 0);
    check("rst_ack0",  {31'b0, bus.ack0}, 0);
    check("rst_ack1",  {31'b0, bus.ack1}, 0);
    check("rst_addr",  bus.mem_addr, 0);
    check("rst_rdata", bus.rdata, 0);
    reset_n = 1'b1;
    tick();

    // port0 transaction moves pointer to port1
    bus.req0 = 1'b1; bus.addr0 = 32'h4;
    tick();
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'h11;
    tick();
    check("pre_ack0", {31'b0, bus.ack0}, 1);
    idle_in();
    tick();
    // port1 in flight, then async reset
    bus.req1 = 1'b1; bus.addr1 = 32'h8;
    tick();
    check("pre_busy", {31'b0, bus.mem_valid}, 1);
    check("pre_addr", bus.mem_addr, 32'h8);
    #2 reset_n = 1'b0;
    #1;
    check("mid_valid", {31'b0, bus.mem_valid}, 0);
    check("mid_ack0",  {31'b0, bus.ack0}, 0);
    check("mid_ack1",  {31'b0, bus.ack1}, 0);
    tick();
    check("mid_ack1b", {31'b0, bus.ack1}, 0);
    idle_in();
    reset_n = 1'b1;
    tick();
    bus.req0 = 1'b1; bus.addr0 = 32'h4;
    bus.req1 = 1'b1; bus.addr1 = 32'h8;
    tick();
    check("rr_after_rst", bus.mem_addr, 32'h4);
    bus.mem_ready = 1'b1;
    tick();
    check("rr_ack0", {31'b0, bus.ack0}, 1);
    idle_in();
    tick();

    // single read with two wait cycles
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 32'h10;
    tick();
    check("rd_valid", {31'b0, bus.mem_valid}, 1);
    check("rd_addr",  bus.mem_addr, 32'h10);
    check("rd_we",    {31'b0, bus.mem_we}, 0);
    tick();
    check("rd_ack_early", {31'b0, bus.ack0}, 0);
    tick();
    check("rd_hold", {31'b0, bus.mem_valid}, 1);
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'hDEADBEEF;
    tick();
    check("rd_ack0",  {31'b0, bus.ack0}, 1);
    check("rd_ack1",  {31'b0, bus.ack1}, 0);
    check("rd_err0",  {31'b0, bus.err0}, 0);
    check("rd_data",  bus.rdata, 32'hDEADBEEF);
    check("rd_vdrop", {31'b0, bus.mem_valid}, 0);
    idle_in();
    tick();
    check("rd_pulse", {31'b0, bus.ack0}, 0);

    // contention from reset alternates 0,1,0,1
    do_reset();
    bus.req0 = 1'b1; bus.addr0 = 32'h100;
    bus.req1 = 1'b1; bus.addr1 = 32'h200;
    for (int i = 0; i < 4; i++) begin
      exp_port = i[0];
      exp_addr = exp_port ? 32'h200 : 32'h100;
      tick();
      check($sformatf("ct_addr%0d", i), bus.mem_addr, exp_addr);
      bus.mem_ready = 1'b1;
      bus.mem_rdata = 32'hA5A50000 + i;
      tick();
      check($sformatf("ct_ack0_%0d", i),
            {31'b0, bus.ack0}, {31'b0, !exp_port});
      check($sformatf("ct_ack1_%0d", i),
            {31'b0, bus.ack1}, {31'b0, exp_port});
      bus.mem_ready = 1'b0;
      if (i == 3) begin
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
      end
      tick();
      check($sformatf("ct_idle%0d", i),
            {31'b0, bus.mem_valid}, 0);
    end
    check("ct_rdata", bus.rdata, 32'hA5A50003);
`ifdef DMEM_ARB_PERF_EN
    check("ct_conflict", {16'b0, conflict_cnt}, 4);
`endif

    // write from port1 leaves rdata alone
    bus.req1 = 1'b1; bus.we1 = 1'b1;
    bus.addr1 = 32'h40; bus.wdata1 = 32'h12345678;
    tick();
    check("wr_we",    {31'b0, bus.mem_we}, 1);
    check("wr_addr",  bus.mem_addr, 32'h40);
    check("wr_wdata", bus.mem_wdata, 32'h12345678);
    tick();
    check("wr_hold",  bus.mem_wdata, 32'h12345678);
    check("wr_vhold", {31'b0, bus.mem_valid}, 1);
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'hBAD0BAD0;
    tick();
    check("wr_ack1",  {31'b0, bus.ack1}, 1);
    check("wr_ack0",  {31'b0, bus.ack0}, 0);
    check("wr_err1",  {31'b0, bus.err1}, 0);
    check("wr_rdata", bus.rdata, 32'hA5A50003);
    idle_in();
    tick();

    // timeout: four silent busy cycles
    bus.req0 = 1'b1; bus.addr0 = 32'h80;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("to_busy%0d", i),
            {31'b0, bus.mem_valid}, 1);
    end
    tick();
    check("to_valid", {31'b0, bus.mem_valid}, 0);
    check("to_ack0",  {31'b0, bus.ack0}, 1);
    check("to_err0",  {31'b0, bus.err0}, 1);
    check("to_ack1",  {31'b0, bus.ack1}, 0);
    check("to_rdata", bus.rdata, 32'hA5A50003);
`ifdef DMEM_ARB_PERF_EN
    check("to_cnt", {24'b0, timeout_cnt}, 1);
`endif
    idle_in();
    tick();

    // ready lands exactly in the timeout cycle
    bus.req0 = 1'b1; bus.addr0 = 32'h84;
    tick();
    tick();
    tick();
    tick();
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'hCAFEF00D;
    tick();
    check("race_ack0",  {31'b0, bus.ack0}, 1);
    check("race_err0",  {31'b0, bus.err0}, 0);
    check("race_rdata", bus.rdata, 32'hCAFEF00D);
`ifdef DMEM_ARB_PERF_EN
    check("race_cnt", {24'b0, timeout_cnt}, 1);
`endif
    idle_in();
    tick();
    check("end_idle", {31'b0, bus.mem_valid}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
